// File: rtl/program_sequencer_pkg.sv
// Shared types for the program sequencer: decoder opcodes and FSM state encoding.
package sequencer_pkg;

    typedef enum logic [2:0] {
        OP_NEXT = 3'd0,
        OP_SKIP = 3'd1,
        OP_JMP  = 3'd2,
        OP_JSR  = 3'd3,
        OP_RTN  = 3'd4
    } seq_op_t;

    typedef enum logic [1:0] {
        BOOT     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_CMD = 2'd2,
        FAULT    = 2'd3
    } seq_state_t;

endpackage

// File: rtl/program_sequencer_return_stack.sv
// LIFO return-address stack; push on full and pop on empty are ignored.
module return_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             data_in,
    output logic [WIDTH-1:0]             data_out,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   depth
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [CW-1:0]    depth_r;
    logic [IW-1:0]    wr_idx_s;
    logic [IW-1:0]    rd_idx_s;
    logic             full_s;
    logic             empty_s;

    assign full_s   = (depth_r == DEPTH_C);
    assign empty_s  = (depth_r == {CW{1'b0}});
    assign wr_idx_s = IW'(depth_r);
    assign rd_idx_s = IW'(depth_r - CW'(1));

    // Stack storage and occupancy; push takes priority if both are ever raised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            depth_r <= {CW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else if (push && !full_s) begin
            mem_r[wr_idx_s] <= data_in;
            depth_r         <= depth_r + CW'(1);
        end else if (pop && !empty_s) begin
            depth_r <= depth_r - CW'(1);
        end else begin
            depth_r <= depth_r;
        end
    end

    assign data_out = mem_r[rd_idx_s];
    assign full     = full_s;
    assign empty    = empty_s;
    assign depth    = depth_r;

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address sequencer: alternates issuing the PC to program memory and
// accepting a decoder command that selects the next PC (advance/skip/jump/call/return).
module program_sequencer
    import sequencer_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    STACK_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_ADDR  = '0
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               cmd_valid,
    output logic                               cmd_ready,
    input  logic [2:0]                         cmd_op,
    input  logic [ADDR_WIDTH-1:0]              cmd_target,
    output logic                               addr_valid,
    input  logic                               addr_ready,
    output logic [ADDR_WIDTH-1:0]              addr_out,
    output logic                               jmp_pulse,
    output logic                               rtn_pulse,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_depth,
    output logic                               fault
);

    seq_state_t            state_r;
    seq_state_t            state_next_s;
    logic [ADDR_WIDTH-1:0] pc_r;
    logic [ADDR_WIDTH-1:0] pc_next_s;
    logic [ADDR_WIDTH-1:0] pc_inc_s;
    logic [ADDR_WIDTH-1:0] stack_top_s;
    logic                  push_s;
    logic                  pop_s;
    logic                  jmp_s;
    logic                  rtn_s;
    logic                  fault_set_s;
    logic                  stack_full_s;
    logic                  stack_empty_s;
    logic                  jmp_pulse_r;
    logic                  rtn_pulse_r;
    logic                  fault_r;

    assign pc_inc_s = pc_r + ADDR_WIDTH'(1);

    return_stack #(
        .WIDTH (ADDR_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk      (clk),
        .reset    (reset),
        .push     (push_s),
        .pop      (pop_s),
        .data_in  (pc_inc_s),
        .data_out (stack_top_s),
        .full     (stack_full_s),
        .empty    (stack_empty_s),
        .depth    (stack_depth)
    );

    // Next-state and next-PC selection; a command is only consumed in WAIT_CMD.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        push_s       = 1'b0;
        pop_s        = 1'b0;
        jmp_s        = 1'b0;
        rtn_s        = 1'b0;
        fault_set_s  = 1'b0;
        case (state_r)
            BOOT: begin
                state_next_s = ISSUE;
            end
            ISSUE: begin
                if (addr_ready) begin
                    state_next_s = WAIT_CMD;
                end else begin
                    state_next_s = ISSUE;
                end
            end
            WAIT_CMD: begin
                if (cmd_valid) begin
                    state_next_s = ISSUE;
                    case (seq_op_t'(cmd_op))
                        OP_NEXT: pc_next_s = pc_inc_s;
                        OP_SKIP: pc_next_s = pc_r + ADDR_WIDTH'(2);
                        OP_JMP: begin
                            pc_next_s = cmd_target;
                            jmp_s     = 1'b1;
                        end
                        OP_JSR: begin
                            if (stack_full_s) begin
                                fault_set_s  = 1'b1;
                                state_next_s = FAULT;
                            end else begin
                                push_s    = 1'b1;
                                jmp_s     = 1'b1;
                                pc_next_s = cmd_target;
                            end
                        end
                        OP_RTN: begin
                            if (stack_empty_s) begin
                                fault_set_s  = 1'b1;
                                state_next_s = FAULT;
                            end else begin
                                pop_s     = 1'b1;
                                rtn_s     = 1'b1;
                                pc_next_s = stack_top_s;
                            end
                        end
                        default: pc_next_s = pc_inc_s;
                    endcase
                end else begin
                    state_next_s = WAIT_CMD;
                end
            end
            FAULT: begin
                state_next_s = FAULT;
            end
            default: begin
                state_next_s = FAULT;
                fault_set_s  = 1'b1;
            end
        endcase
    end

    // State, PC, sticky fault and one-cycle pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= BOOT;
            pc_r        <= RESET_ADDR;
            jmp_pulse_r <= 1'b0;
            rtn_pulse_r <= 1'b0;
            fault_r     <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            pc_r        <= pc_next_s;
            jmp_pulse_r <= jmp_s;
            rtn_pulse_r <= rtn_s;
            fault_r     <= fault_r | fault_set_s;
        end
    end

    assign addr_valid = (state_r == ISSUE);
    assign cmd_ready  = (state_r == WAIT_CMD);
    assign addr_out   = pc_r;
    assign jmp_pulse  = jmp_pulse_r;
    assign rtn_pulse  = rtn_pulse_r;
    assign fault      = fault_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Scoreboard bench for program_sequencer: expected fetch addresses are queued by
// the stimulus and checked by an independent monitor when memory accepts a fetch.
module tb_program_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [2:0] cmd_op = 3'd0;
    logic [7:0] cmd_target = 8'h00;
    logic       addr_valid;
    logic       addr_ready = 1'b0;
    logic [7:0] addr_out;
    logic       jmp_pulse;
    logic       rtn_pulse;
    logic [2:0] stack_depth;
    logic       fault;

    logic       cmd_ready2;
    logic       addr_valid2;
    logic [7:0] addr_out2;
    logic       jmp_pulse2;
    logic       rtn_pulse2;
    logic [2:0] stack_depth2;
    logic       fault2;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_q[$];

    program_sequencer #(.ADDR_WIDTH(8), .STACK_DEPTH(4), .RESET_ADDR(8'h00)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_target(cmd_target), .addr_valid(addr_valid),
        .addr_ready(addr_ready), .addr_out(addr_out), .jmp_pulse(jmp_pulse),
        .rtn_pulse(rtn_pulse), .stack_depth(stack_depth), .fault(fault)
    );

    program_sequencer #(.ADDR_WIDTH(8), .STACK_DEPTH(4), .RESET_ADDR(8'h20)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(1'b0), .cmd_ready(cmd_ready2),
        .cmd_op(3'd0), .cmd_target(8'h00), .addr_valid(addr_valid2),
        .addr_ready(1'b0), .addr_out(addr_out2), .jmp_pulse(jmp_pulse2),
        .rtn_pulse(rtn_pulse2), .stack_depth(stack_depth2), .fault(fault2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: handshake exclusivity every cycle, and fetch addresses against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            chk("valid_ready_exclusive", 32'(addr_valid & cmd_ready), 32'd0);
            if (addr_valid && addr_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_fetch actual=%0h required=none", addr_out);
                end else begin
                    chk("fetch_addr", 32'(addr_out), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_addr_valid", 32'(addr_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_addr_out", 32'(addr_out), 32'h00);
        chk("rst_depth", 32'(stack_depth), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_pulses", 32'({jmp_pulse, rtn_pulse}), 32'd0);
        chk("rst2_addr_out", 32'(addr_out2), 32'h20);
        chk("rst2_fault", 32'(fault2), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("boot_addr_valid", 32'(addr_valid), 32'd0);
    endtask

    task automatic fetch();
        int n = 0;
        while (!addr_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!addr_valid) begin
            total++;
            bad++;
            $display("FAIL fetch_timeout actual=addr_valid_low required=addr_valid_high");
        end else begin
            addr_ready = 1'b1;
            @(posedge clk);
            #1;
            addr_ready = 1'b0;
            chk("cmd_ready_after_fetch", 32'(cmd_ready), 32'd1);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [7:0] tgt, input logic ok,
                         input logic [7:0] exp_pc, input logic exp_j, input logic exp_r,
                         input logic do_fetch);
        int n = 0;
        while (!cmd_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            total++;
            bad++;
            $display("FAIL cmd_timeout actual=cmd_ready_low required=cmd_ready_high");
        end else begin
            if (ok) exp_q.push_back(exp_pc);
            cmd_valid  = 1'b1;
            cmd_op     = op;
            cmd_target = tgt;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            chk("jmp_pulse", 32'(jmp_pulse), 32'(exp_j));
            chk("rtn_pulse", 32'(rtn_pulse), 32'(exp_r));
            chk("addr_valid_after_cmd", 32'(addr_valid), 32'(ok));
            if (ok && do_fetch) fetch();
        end
    endtask

    initial begin
        #2;
        do_reset();

        // 1: sequential advance
        exp_q.push_back(8'h00);
        fetch();
        issue(3'd0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
        issue(3'd0, 8'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b1);
        issue(3'd0, 8'h00, 1'b1, 8'h03, 1'b0, 1'b0, 1'b1);

        // 2: wrap and skip, reserved ops as NEXT
        issue(3'd2, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        issue(3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        issue(3'd2, 8'hFE, 1'b1, 8'hFE, 1'b1, 1'b0, 1'b1);
        issue(3'd1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1);
        issue(3'd2, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0, 1'b1);
        issue(3'd1, 8'h00, 1'b1, 8'h12, 1'b0, 1'b0, 1'b1);
        issue(3'd5, 8'h99, 1'b1, 8'h13, 1'b0, 1'b0, 1'b1);
        issue(3'd7, 8'h99, 1'b1, 8'h14, 1'b0, 1'b0, 1'b1);
        chk("reserved_no_fault", 32'(fault), 32'd0);

        // 3: nested calls and returns
        issue(3'd2, 8'h01, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        chk("depth1", 32'(stack_depth), 32'd1);
        issue(3'd3, 8'h50, 1'b1, 8'h50, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h60, 1'b1, 8'h60, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h70, 1'b1, 8'h70, 1'b1, 1'b0, 1'b1);
        chk("depth4", 32'(stack_depth), 32'd4);
        issue(3'd4, 8'h00, 1'b1, 8'h61, 1'b0, 1'b1, 1'b1);
        chk("depth3", 32'(stack_depth), 32'd3);
        issue(3'd4, 8'h00, 1'b1, 8'h51, 1'b0, 1'b1, 1'b1);
        issue(3'd4, 8'h00, 1'b1, 8'h41, 1'b0, 1'b1, 1'b1);
        issue(3'd4, 8'h00, 1'b1, 8'h02, 1'b0, 1'b1, 1'b1);
        chk("depth0", 32'(stack_depth), 32'd0);

        // pushed return address wraps
        issue(3'd2, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h30, 1'b1, 8'h30, 1'b1, 1'b0, 1'b1);
        issue(3'd4, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1);

        // 4: overflow faults and freezes
        issue(3'd3, 8'h40, 1'b1, 8'h40, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h50, 1'b1, 8'h50, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h60, 1'b1, 8'h60, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h70, 1'b1, 8'h70, 1'b1, 1'b0, 1'b1);
        issue(3'd3, 8'h80, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("ovf_fault", 32'(fault), 32'd1);
        chk("ovf_depth", 32'(stack_depth), 32'd4);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("ovf_addr_frozen", 32'(addr_out), 32'h70);
            chk("ovf_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("ovf_fault_sticky", 32'(fault), 32'd1);
        end

        // 5: underflow, then reset clears the fault; alternate reset address
        do_reset();
        exp_q.push_back(8'h00);
        fetch();
        issue(3'd4, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("unf_fault", 32'(fault), 32'd1);
        chk("unf_addr", 32'(addr_out), 32'h00);
        chk("unf_depth", 32'(stack_depth), 32'd0);
        chk("alt_addr_valid", 32'(addr_valid2), 32'd1);
        chk("alt_addr_out", 32'(addr_out2), 32'h20);
        chk("alt_fault", 32'(fault2), 32'd0);

        // 6: fetch stall, then reset mid-stall
        do_reset();
        exp_q.push_back(8'h00);
        fetch();
        issue(3'd3, 8'h55, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("stall_addr", 32'(addr_out), 32'h55);
            chk("stall_valid", 32'(addr_valid), 32'd1);
        end
        chk("stall_depth", 32'(stack_depth), 32'd1);
        do_reset();
        exp_q.push_back(8'h00);
        fetch();

        @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
